// File: rtl/mram_ctrl.sv
// mram_ctrl: turns single-word host requests into timed MRAM pin cycles and returns read data.
module mram_ctrl #(
  parameter int ADDR_WIDTH = 20,
  parameter int RD_LAT     = 2,
  parameter int WR_CYC     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]           req_wdata,
  input  logic [1:0]            req_be,
  output logic                  rsp_valid,
  output logic [15:0]           rsp_rdata,
  output logic                  mram_en,
  output logic                  mram_we_n,
  output logic                  mram_lb_n,
  output logic                  mram_ub_n,
  output logic [ADDR_WIDTH-1:0] mram_addr,
  output logic [15:0]           dq_o,
  output logic                  dq_oe,
  input  logic [15:0]           dq_i
);
  localparam int CW = $clog2((RD_LAT > WR_CYC ? RD_LAT : WR_CYC) + 1);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    be_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      be_q      <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mram_en   <= 1'b0;
      mram_we_n <= 1'b1;
      mram_lb_n <= 1'b1;
      mram_ub_n <= 1'b1;
      mram_addr <= '0;
      dq_o      <= '0;
      dq_oe     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            // A request with no lanes enabled still runs its full timing, just with pins quiet.
            state     <= req_write ? WRITE : READ;
            req_ready <= 1'b0;
            cnt       <= '0;
            be_q      <= req_be;
            mram_en   <= |req_be;
            mram_we_n <= ~(req_write && |req_be);
            mram_lb_n <= ~req_be[0];
            mram_ub_n <= ~req_be[1];
            mram_addr <= req_addr;
            dq_oe     <= req_write && |req_be;
            if (req_write) dq_o <= req_wdata;
          end
        end
        WRITE: begin
          if (cnt == CW'(WR_CYC - 1)) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            {mram_en, mram_we_n, mram_lb_n, mram_ub_n, dq_oe} <= 5'b01110;
          end else cnt <= cnt + 1'b1;
        end
        READ: begin
          if (cnt == CW'(RD_LAT - 1)) begin
            state     <= RESP;
            cnt       <= '0;
            rsp_valid <= 1'b1;
            rsp_rdata <= {be_q[1] ? dq_i[15:8] : 8'h00, be_q[0] ? dq_i[7:0] : 8'h00};
            {mram_en, mram_we_n, mram_lb_n, mram_ub_n, dq_oe} <= 5'b01110;
          end else cnt <= cnt + 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          cnt       <= '0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mram_ctrl.sv
// tb_mram_ctrl: directed bench with an MRAM device model and a cycle-count transaction model.
module tb_mram_ctrl;
  localparam int AW = 20, RD_LAT = 2, WR_CYC = 1;
  logic          clk = 0, rst_n = 1;
  logic          req_valid = 0, req_write = 0;
  logic [AW-1:0] req_addr = 0;
  logic [15:0]   req_wdata = 0;
  logic [1:0]    req_be = 0;
  logic          req_ready, rsp_valid, mram_en, mram_we_n, mram_lb_n, mram_ub_n, dq_oe;
  logic [15:0]   rsp_rdata, dq_o, dq_i;
  logic [AW-1:0] mram_addr;
  int vectors = 0, miscompares = 0;
  logic [15:0] mem [0:255];

  mram_ctrl #(.ADDR_WIDTH(AW), .RD_LAT(RD_LAT), .WR_CYC(WR_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mram_en(mram_en), .mram_we_n(mram_we_n),
    .mram_lb_n(mram_lb_n), .mram_ub_n(mram_ub_n), .mram_addr(mram_addr),
    .dq_o(dq_o), .dq_oe(dq_oe), .dq_i(dq_i));

  always #5 clk = ~clk;

  // External MRAM: byte-lane writes on strobe, read data visible while enabled for read.
  assign dq_i = (mram_en && mram_we_n) ? mem[mram_addr[7:0]] : 16'hDEAD;
  always @(posedge clk) if (mram_en && !mram_we_n && dq_oe) begin
    if (!mram_lb_n) mem[mram_addr[7:0]][7:0] <= dq_o[7:0];
    if (!mram_ub_n) mem[mram_addr[7:0]][15:8] <= dq_o[15:8];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Transaction model: m_k counts edges since the accept, 0 means no transaction in flight.
  int m_k = 0;
  bit m_ready = 0, m_w = 0;
  logic [1:0]    m_be = 0;
  logic [AW-1:0] last_addr = 0;
  logic [15:0]   last_dq = 0, exp_rdata = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_ready = 0; m_w = 0; m_be = 0; last_addr = 0; last_dq = 0; exp_rdata = 0;
    end else if (m_k == 0) begin
      if (m_ready && req_valid) begin
        m_k = 1; m_ready = 0; m_w = req_write; m_be = req_be; last_addr = req_addr;
        if (req_write) last_dq = req_wdata;
      end else m_ready = 1;
    end else if (m_k == (m_w ? WR_CYC : RD_LAT + 1)) begin
      m_k = 0; m_ready = 1;
    end else begin
      m_k++;
      if (!m_w && m_k == RD_LAT + 1)
        exp_rdata = mem[last_addr[7:0]] & {{8{m_be[1]}}, {8{m_be[0]}}};
    end
  end

  always @(negedge clk) begin
    bit act, on;
    act = m_k >= 1 && m_k <= (m_w ? WR_CYC : RD_LAT);
    on  = act && |m_be;
    chk("req_ready", req_ready, m_ready);
    chk("mram_en", mram_en, on);
    chk("mram_we_n", mram_we_n, !(on && m_w));
    chk("mram_lb_n", mram_lb_n, !(act && m_be[0]));
    chk("mram_ub_n", mram_ub_n, !(act && m_be[1]));
    chk("dq_oe", dq_oe, on && m_w);
    chk("rsp_valid", rsp_valid, !m_w && m_k == RD_LAT + 1);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("mram_addr", mram_addr, last_addr);
    chk("dq_o", dq_o, last_dq);
    chk("oe_while_we_n", dq_oe && mram_we_n, 0);
  end

  // Called at a negedge; returns at the negedge after the accepting edge with t = edge count.
  int cyc = 0;
  always @(posedge clk) cyc++;
  task automatic send(input bit w, input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] b, output int t);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_be = b;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    t = cyc;
  endtask

  // Returns the cycle number (1 = first cycle after accept) in which rsp_valid appears.
  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  initial begin
    int t1, t2, t3, n;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[7] = 16'h1111;
    mem[8'h20] = 16'hCAFE;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_we_n", mram_we_n, 1);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);
    chk("idle_en", mram_en, 0);

    send(1, 20'h12345, 16'hBEEF, 2'b11, t1);
    req_valid = 0;
    chk("fw_en", mram_en, 1);
    chk("fw_we_n", mram_we_n, 0);
    chk("fw_lanes", {mram_ub_n, mram_lb_n}, 2'b00);
    chk("fw_dq_o", dq_o, 16'hBEEF);
    chk("fw_dq_oe", dq_oe, 1);
    chk("fw_addr", mram_addr, 20'h12345);
    @(negedge clk);
    chk("fw_ready_back", req_ready, 1);

    send(1, 20'd7, 16'hA55A, 2'b01, t1);
    req_valid = 0;
    chk("pw_lb_n", mram_lb_n, 0);
    chk("pw_ub_n", mram_ub_n, 1);
    @(negedge clk);
    send(0, 20'd7, 16'h0000, 2'b11, t1);
    req_valid = 0;
    wait_rsp(n);
    chk("rd_cycle", n, 3);
    chk("rd_data", rsp_rdata, 16'h115A);
    @(negedge clk);
    chk("rd_pulse_one", rsp_valid, 0);
    chk("rd_hold", rsp_rdata, 16'h115A);

    send(0, 20'h20, 16'h0000, 2'b10, t1);
    req_valid = 0;
    chk("mr_lb_n", mram_lb_n, 1);
    wait_rsp(n);
    chk("mr_data", rsp_rdata, 16'hCA00);

    @(negedge clk);
    send(1, 20'd9, 16'h1234, 2'b11, t1);
    send(1, 20'd10, 16'h5678, 2'b11, t2);
    send(0, 20'd9, 16'h0000, 2'b11, t3);
    req_valid = 0;
    chk("b2b_ww", t2 - t1, 2);
    chk("b2b_wr", t3 - t2, 2);
    wait_rsp(n);
    chk("b2b_rsp", n, 3);
    chk("b2b_data", rsp_rdata, 16'h1234);

    @(negedge clk);
    send(1, 20'd9, 16'hFFFF, 2'b00, t1);
    req_valid = 0;
    chk("z_wr_en", mram_en, 0);
    @(negedge clk);
    send(0, 20'd9, 16'h0000, 2'b00, t1);
    req_valid = 0;
    wait_rsp(n);
    chk("z_rd_cycle", n, 3);
    chk("z_rd_data", rsp_rdata, 16'h0000);
    chk("z_wr_kept", mem[9], 16'h1234);

    @(negedge clk);
    send(0, 20'd7, 16'h0000, 2'b11, t1);
    req_valid = 0;
    chk("mid_en_pre", mram_en, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_en", mram_en, 0);
    chk("mid_oe", dq_oe, 0);
    chk("mid_rsp", rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", rsp_valid, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
